barrel_shifter_pipe: RTL and testbench

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

---
 rtl/bs_pkg.sv | 17 +
 rtl/barrel_shifter_pipe_if.sv | 33 +++
 rtl/bs_stage.sv | 79 +++++++
 rtl/barrel_shifter_pipe.sv | 59 +++++
 tb/tb_barrel_shifter_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/bs_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: shift-mode encodings used by the pipeline, its stages and the bus interface.
package bs_pkg;

  localparam int MODE_W = 2;

  // Shift modes, carried with every beat through the pipeline.
  typedef enum logic [MODE_W-1:0] {
    MODE_LSR = 2'b00,  // logical right, zero fill
    MODE_ASR = 2'b01,  // arithmetic right, sign fill
    MODE_LSL = 2'b10,  // logical left, zero fill
    MODE_ROR = 2'b11   // rotate right
  } mode_e;

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Valid/ready bus for the pipelined barrel shifter: one input channel, one result channel.
// Latency: n/a (wires only).
// Backpressure: in_ready from the shifter, out_ready from the consumer.
// Ports: master = producer/consumer side (bench or upstream logic), slave = the shifter.
interface barrel_shifter_pipe_if
  import bs_pkg::*;
#(
  parameter int W  = 10,
  parameter int SW = 3
);

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              in_x;
  logic [SW-1:0]     in_amt;
  logic [MODE_W-1:0] in_mode;

  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;

  modport master (
    output in_valid, in_data, in_x, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_x, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/bs_stage.sv
// One pipeline stage: shifts by SHIFT when its amount bit is set, then registers the beat.
// Latency: 1 cycle.
// Backpressure: en_i low holds every register (global pipeline stall).
// Ports: clk/rst, en_i, beat in (vld/dat/amt/mode _i), registered beat out (_o).
module bs_stage
  import bs_pkg::*;
#(
  parameter int W     = 10,
  parameter int SW    = 3,
  parameter int SHIFT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          vld_i,
  input  logic [W-1:0]  dat_i,
  input  logic [SW-1:0] amt_i,
  input  mode_e         mode_i,
  output logic          vld_o,
  output logic [W-1:0]  dat_o,
  output logic [SW-1:0] amt_o,
  output mode_e         mode_o
);

  // Which bit of the shift amount this stage obeys.
  localparam int K = $clog2(SHIFT);

  logic          vld_q,  vld_d;
  logic [W-1:0]  dat_q,  dat_d;
  logic [SW-1:0] amt_q,  amt_d;
  mode_e         mode_q, mode_d;
  logic [W-1:0]  shifted;

  // Arithmetic right keeps the MSB of the stage input; since earlier stages
  // preserve the sign, that is the sign of the gated operand.
  always_comb begin
    shifted = dat_i;
    unique case (mode_i)
      MODE_LSR: shifted = dat_i >> SHIFT;
      MODE_ASR: shifted = W'($signed(dat_i) >>> SHIFT);
      MODE_LSL: shifted = dat_i << SHIFT;
      MODE_ROR: shifted = (dat_i >> SHIFT) | (dat_i << (W - SHIFT));
      default:  shifted = dat_i;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    amt_d  = amt_q;
    mode_d = mode_q;
    if (en_i) begin
      vld_d  = vld_i;
      dat_d  = amt_i[K] ? shifted : dat_i;
      amt_d  = amt_i;
      mode_d = mode_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      amt_q  <= '0;
      mode_q <= MODE_LSR;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      amt_q  <= amt_d;
      mode_q <= mode_d;
    end
  end

  assign vld_o  = vld_q;
  assign dat_o  = dat_q;
  assign amt_o  = amt_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSR/ASR/LSL/ROR) on a valid/ready bus, SW log-shift stages.
// Latency: SW cycles from acceptance to out_valid; one beat per cycle when unstalled.
// Backpressure: whole pipe stalls when the output holds a beat that is not taken; in_ready mirrors that.
// Ports: clk, rst (sync, active high), bus (slave side of barrel_shifter_pipe_if).
module barrel_shifter_pipe
  import bs_pkg::*;
#(
  parameter int W  = 10,
  parameter int SW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  barrel_shifter_pipe_if.slave bus
);

  logic                  advance;
  logic [SW:0]           vld_s;
  logic [SW:0][W-1:0]    dat_s;
  logic [SW:0][SW-1:0]   amt_s;
  mode_e [SW:0]          mode_s;
  logic                  unused_tail;

  // Only the last stage can block: bubbles further up are overwritten as the pipe moves.
  assign advance      = !vld_s[SW] || bus.out_ready;
  assign bus.in_ready = advance;

  // Element 0 is the incoming beat; the gate bit zeroes the operand up front.
  assign vld_s[0]  = bus.in_valid;
  assign dat_s[0]  = bus.in_data & {W{bus.in_x}};
  assign amt_s[0]  = bus.in_amt;
  assign mode_s[0] = mode_e'(bus.in_mode);

  for (genvar k = 0; k < SW; k++) begin : g_stage
    bs_stage #(
      .W    (W),
      .SW   (SW),
      .SHIFT(1 << k)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en_i  (advance),
      .vld_i (vld_s[k]),
      .dat_i (dat_s[k]),
      .amt_i (amt_s[k]),
      .mode_i(mode_s[k]),
      .vld_o (vld_s[k+1]),
      .dat_o (dat_s[k+1]),
      .amt_o (amt_s[k+1]),
      .mode_o(mode_s[k+1])
    );
  end

  assign bus.out_valid = vld_s[SW];
  assign bus.out_data  = dat_s[SW];

  // Amount and mode are spent once the last stage has shifted.
  assign unused_tail = ^{amt_s[SW], mode_s[SW]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at W=10, SW=3.
// Latency: expects results 3 cycles after acceptance.
// Backpressure: exercises output stalls, reset flush and back-to-back streaming.
module tb_barrel_shifter_pipe;
  import bs_pkg::*;

  localparam int W  = 10;
  localparam int SW = 3;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  barrel_shifter_pipe_if #(.W(W), .SW(SW)) bus ();

  barrel_shifter_pipe #(.W(W), .SW(SW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference of the shift function.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic x,
                                         input int a, input int m);
    logic [W-1:0] g;
    logic [W-1:0] r;
    g = x ? d : '0;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (m)
        0:       r[i] = (i + a < W) ? g[i+a] : 1'b0;
        1:       r[i] = (i + a < W) ? g[i+a] : g[W-1];
        2:       r[i] = (i >= a) ? g[i-a] : 1'b0;
        default: r[i] = g[(i+a)%W];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic x,
                       input int a, input int m);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_x     = x;
    bus.in_amt   = SW'(a);
    bus.in_mode  = 2'(m);
  endtask

  // Send one beat into an empty pipe and check its latency and result.
  task automatic run_beat(input string tag, input logic [W-1:0] d, input logic x,
                          input int a, input int m, input logic [W-1:0] exp);
    int lat;
    bit seen;
    bus.out_ready = 1'b1;
    drive(1'b1, d, x, a, m);
    tick();
    drive(1'b0, '0, 1'b0, 0, 0);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.out_valid) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_dat"}, 32'(bus.out_data), 32'(exp));
    tick();
  endtask

  logic [W-1:0] bp_d   [6] = '{10'h123, 10'h2F0, 10'h081, 10'h3C3, 10'h200, 10'h055};
  int           bp_a   [6] = '{1, 2, 3, 4, 5, 6};
  int           bp_m   [6] = '{0, 1, 2, 3, 1, 3};

  initial begin
    int           sent;
    int           rcv;
    bit           was_stall;
    logic [W-1:0] stall_dat;

    rst           = 1'b1;
    bus.out_ready = 1'b1;
    // A beat offered during reset must never be taken.
    drive(1'b1, 10'h3FF, 1'b1, 0, 0);
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);

    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 0, 0);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_beat_dropped", 32'(bus.out_valid), 32'd0);
    end

    // Hand-computed single beats.
    run_beat("asr_200_3", 10'h200, 1'b1, 3, 1, 10'h3C0);
    run_beat("lsr_200_3", 10'h200, 1'b1, 3, 0, 10'h040);
    run_beat("lsl_0ff_2", 10'h0FF, 1'b1, 2, 2, 10'h3FC);
    run_beat("ror_001_1", 10'h001, 1'b1, 1, 3, 10'h200);
    run_beat("ror_3ff_7", 10'h3FF, 1'b1, 7, 3, 10'h3FF);
    run_beat("ror_0f3_0", 10'h0F3, 1'b1, 0, 3, 10'h0F3);
    run_beat("asr_155_0", 10'h155, 1'b1, 0, 1, 10'h155);
    run_beat("asr_155_2", 10'h155, 1'b1, 2, 1, 10'h055);

    // Gate bit low: every mode and amount gives zero.
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 8; a += 3) begin
        run_beat("gate_x0", 10'h2AB, 1'b0, a, m, 10'h000);
      end
    end

    // Backpressure: 6 beats, out_ready low for cycles 4-7.
    sent      = 0;
    rcv       = 0;
    was_stall = 1'b0;
    stall_dat = '0;
    for (int c = 0; c < 25; c++) begin
      bus.out_ready = !(c >= 4 && c <= 7);
      if (sent < 6) drive(1'b1, bp_d[sent], 1'b1, bp_a[sent], bp_m[sent]);
      else drive(1'b0, '0, 1'b0, 0, 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (rcv < 6) chk("bp_order", 32'(bus.out_data),
                         32'(model(bp_d[rcv], 1'b1, bp_a[rcv], bp_m[rcv])));
        rcv++;
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        if (was_stall) chk("bp_stable", 32'(bus.out_data), 32'(stall_dat));
        stall_dat = bus.out_data;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    chk("bp_count", 32'(rcv), 32'd6);
    drive(1'b0, '0, 1'b0, 0, 0);
    bus.out_ready = 1'b1;

    // Reset with 3 beats in flight.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 10'h3A5, 1'b1, c, c);
      tick();
    end
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, 10'h111, 1'b1, 1, 0);
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, 1'b0, 0, 0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flush_none", 32'(bus.out_valid), 32'd0);
    end
    run_beat("post_flush", 10'h0F0, 1'b1, 4, 0, 10'h00F);

    // Back-to-back: 8 beats, amt 0..7, modes cycling.
    rcv = 0;
    for (int c = 0; c < 13; c++) begin
      if (c < 8) drive(1'b1, 10'h155, 1'b1, c, c % 4);
      else drive(1'b0, '0, 1'b0, 0, 0);
      #1;
      if (c >= 3 && c <= 10) chk("b2b_no_bubble", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        if (rcv < 8) chk("b2b_dat", 32'(bus.out_data),
                         32'(model(10'h155, 1'b1, rcv, rcv % 4)));
        rcv++;
      end
      tick();
    end
    chk("b2b_count", 32'(rcv), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

endmodule
